// File: rtl/riscv_pkg.sv
// riscv_pkg: control encodings and the ID/EX register layout shared by decode and execute.
package riscv_pkg;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_write;
    logic jump;
    logic branch;
    logic alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idex_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags a decode instruction that reads the destination of a load now in execute.
// Ports: valid_e/result_src_e/rd_e describe the execute slot; rs1_d/rs2_d are decode sources; load_use out.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic       valid_e,
  input  logic [1:0] result_src_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  output logic       load_use
);
  // rs2 is compared even for formats without rs2: a spurious stall is harmless, a missed one is not.
  assign load_use = valid_e && result_src_e == RES_LOAD && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush/invalid bubbles and a saturating bubble counter.
// Ports: *D decode inputs, FlushE redirect, *E registered outputs, StallF/StallD hold, BubbleCount load-use bubbles.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int BC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [31:0]     RD1D,
  input  logic [31:0]     RD2D,
  input  logic [31:0]     ImmExtD,
  input  logic [31:0]     PCD,
  input  logic [31:0]     PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic            ValidE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [31:0]     RD1E,
  output logic [31:0]     RD2E,
  output logic [31:0]     ImmExtE,
  output logic [31:0]     PCE,
  output logic [31:0]     PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            StallF,
  output logic            StallD,
  output logic [BC_W-1:0] BubbleCount
);
  idex_t d, e;
  logic load_use;
  assign d = {ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
              RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};
  assign {ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
          RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = e;
  hazard_detect u_hazard (
    .valid_e(e.valid),
    .result_src_e(e.result_src),
    .rd_e(e.rd),
    .rs1_d(Rs1D),
    .rs2_d(Rs2D),
    .load_use(load_use)
  );
  // A flush discards the held instruction anyway, so stalling under it would only lose a cycle.
  assign StallF = load_use && !FlushE;
  assign StallD = StallF;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e <= '0;
      BubbleCount <= '0;
    end else begin
      e <= (FlushE || load_use || !ValidD) ? '0 : d;
      if (StallF && BubbleCount != '1) BubbleCount <= BubbleCount + 1'b1;
    end
  end
endmodule
